// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART-to-AXI4-Stream receive path.
// Optional timestamp output is enabled by defining UART_RX_TIMESTAMP_EN.
package uart_rx_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 3'd0;
  localparam rx_state_t ST_START = 3'd1;
  localparam rx_state_t ST_DATA  = 3'd2;
  localparam rx_state_t ST_STOP  = 3'd3;
  localparam rx_state_t ST_BREAK = 3'd4;

  localparam int unsigned TS_PULSE_CYCLES = 64;

  // Rounded-to-nearest clock cycles per UART bit.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered read-data output.
// The head register counts as one of the DEPTH slots, so capacity is exactly DEPTH.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_dout;

  logic             w_rd;
  logic             w_wr;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_remain;
  logic [WIDTH-1:0] w_head_nxt;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rd_data = r_dout;

  // A pop frees a slot in the same cycle, so a push while full is accepted.
  assign w_rd         = i_rd_en && !o_empty;
  assign w_wr         = i_wr_en && (!o_full || w_rd);
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_rd);
  assign w_remain     = r_count - CNT_W'(w_rd);

  always_comb begin
    w_head_nxt = r_mem[w_rd_ptr_nxt];
    if (w_remain == '0) begin
      w_head_nxt = i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_remain + CNT_W'(w_wr);
      if (w_remain != '0 || w_wr) begin
        r_dout <= w_head_nxt;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/uart_axis_frame_rx.sv
// UART receiver that packs bytes little-endian into AXI4-Stream beats with per-frame tlast.
// Define UART_RX_TIMESTAMP_EN to add the ts_pin_n energy-measurement pulse output.
module uart_axis_frame_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100000000,
  parameter int unsigned BAUD           = 115200,
  parameter int unsigned BYTES_PER_WORD = 2,
  parameter int unsigned FRAME_WORDS    = 16,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                        sys_clock,
  input  logic                        reset,
  input  logic                        uart_rxd,
  output logic [8*BYTES_PER_WORD-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        frame_err,
  output logic                        overflow,
  input  logic                        clear_err
`ifdef UART_RX_TIMESTAMP_EN
  ,
  output logic                        ts_pin_n
`endif
);

  localparam int unsigned CPB    = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned DIV_W  = $clog2(CPB + 1);
  localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;
  localparam int unsigned IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned CNT_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [DIV_W-1:0] HALF_BIT    = DIV_W'(CPB / 2);
  localparam logic [DIV_W-1:0] FULL_BIT_M1 = DIV_W'(CPB - 1);

  logic [1:0]        r_sync;
  logic              r_rx_prev;
  rx_state_t         r_state;
  logic [DIV_W-1:0]  r_div;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [WORD_W-1:0] r_word;
  logic [IDX_W-1:0]  r_byte_idx;
  logic [CNT_W-1:0]  r_word_cnt;
  logic              r_push;
  logic [WORD_W:0]   r_push_data;
  logic              r_frame_err;
  logic              r_overflow;

  logic              w_rx;
  logic              w_fall;
  logic              w_tick;
  logic              w_byte_ok;
  logic              w_byte_err;
  logic              w_word_last;
  logic              w_frame_last;
  logic [WORD_W-1:0] w_word_next;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_drop;
  logic [WORD_W:0]   w_fifo_dout;

  assign w_rx       = r_sync[1];
  assign w_fall     = r_rx_prev & ~w_rx;
  assign w_tick     = (r_div == '0);
  assign w_byte_ok  = (r_state == ST_STOP) && w_tick && w_rx;
  assign w_byte_err = (r_state == ST_STOP) && w_tick && !w_rx;

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], uart_rxd};
      r_rx_prev <= w_rx;
    end
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_START;
            r_div   <= HALF_BIT;
          end
        end
        ST_START: begin
          if (!w_tick) begin
            r_div <= r_div - 1'b1;
          end else if (w_rx) begin
            r_state <= ST_IDLE;
          end else begin
            r_state   <= ST_DATA;
            r_div     <= FULL_BIT_M1;
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (!w_tick) begin
            r_div <= r_div - 1'b1;
          end else begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_div   <= FULL_BIT_M1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (!w_tick) begin
            r_div <= r_div - 1'b1;
          end else begin
            r_state <= w_rx ? ST_IDLE : ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (w_rx) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_word_next = r_word;
    w_word_next[8*r_byte_idx +: 8] = r_shift;
  end

  assign w_word_last  = (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1));
  assign w_frame_last = (r_word_cnt == CNT_W'(FRAME_WORDS - 1));

  // A framing error drops the partial word but leaves frame alignment untouched.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      r_word      <= '0;
      r_byte_idx  <= '0;
      r_word_cnt  <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_byte_err) begin
        r_byte_idx <= '0;
      end else if (w_byte_ok) begin
        r_word <= w_word_next;
        if (w_word_last) begin
          r_push      <= 1'b1;
          r_push_data <= {w_frame_last, w_word_next};
          r_byte_idx  <= '0;
          r_word_cnt  <= w_frame_last ? '0 : r_word_cnt + 1'b1;
        end else begin
          r_byte_idx <= r_byte_idx + 1'b1;
        end
      end
    end
  end

  assign w_pop  = !w_empty && m_axis_tready;
  assign w_drop = r_push && w_full && !w_pop;

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_byte_err) begin
        r_frame_err <= 1'b1;
      end else if (clear_err) begin
        r_frame_err <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_err) begin
        r_overflow <= 1'b0;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (sys_clock),
    .i_rst_n   (reset),
    .i_wr_en   (r_push),
    .i_wr_data (r_push_data),
    .i_rd_en   (m_axis_tready),
    .o_rd_data (w_fifo_dout),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign m_axis_tvalid = !w_empty;
  assign m_axis_tlast  = w_fifo_dout[WORD_W];
  assign m_axis_tdata  = w_fifo_dout[WORD_W-1:0];
  assign frame_err     = r_frame_err;
  assign overflow      = r_overflow;

`ifdef UART_RX_TIMESTAMP_EN
  localparam int unsigned TS_W = $clog2(TS_PULSE_CYCLES + 1);

  logic [TS_W-1:0] r_ts_cnt;

  // Pin stays low while the count is non-zero; a new tlast restarts the pulse.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      r_ts_cnt <= '0;
    end else if (w_pop && m_axis_tlast) begin
      r_ts_cnt <= TS_W'(TS_PULSE_CYCLES);
    end else if (r_ts_cnt != '0) begin
      r_ts_cnt <= r_ts_cnt - 1'b1;
    end
  end

  assign ts_pin_n = (r_ts_cnt == '0);
`endif

endmodule

// File: doc/uart_axis_frame_rx.md
Name: uart_axis_frame_rx

Overview:
- Inbound host-data stage on the Arty A7-100T board build: deserialises the USB/PMOD UART receive line into bytes.
- Packs the bytes into little-endian words and emits them as an AXI4-Stream master with tlast on each frame boundary.
- Sits directly upstream of the accelerator input DMA/stream port inside design_1, fed by the board UART RX pin.

Parameters:
- CLK_HZ, 100000000, sys_clock frequency in Hz
- BAUD, 115200, line rate; CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD, integer
- BYTES_PER_WORD, 2, bytes packed per stream beat (1..4)
- FRAME_WORDS, 16, beats per frame; tlast on the final beat (>=1)
- FIFO_DEPTH, 8, output word FIFO depth (power of 2, >=2)

Ports:
- sys_clock  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-low reset
- uart_rxd  in  1  asynchronous serial input, idle high
- m_axis_tdata  out  8*BYTES_PER_WORD  packed word, first received byte in [7:0]
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  final beat of frame
- frame_err  out  1  sticky; stop bit sampled 0
- overflow  out  1  sticky; word dropped because FIFO full
- clear_err  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_err=0, overflow=0. Synchroniser flops reset to 1. FSM=IDLE. Counters and FIFO pointers=0.
- Reset mid-byte or mid-frame: everything is discarded; no partial beat is ever emitted.
- uart_rxd passes through a 2-flop synchroniser before any use.
- RX FSM:
  - IDLE: a falling edge moves to START and loads the divider with CLKS_PER_BIT/2.
  - START: resample at mid-bit. If 1 (glitch), return to IDLE. Otherwise go to DATA.
  - DATA: 8 samples, one every CLKS_PER_BIT, LSB first. Then go to STOP.
  - STOP: sample at mid-stop.
    - Sample 1: byte valid; return to IDLE.
    - Sample 0: set frame_err, discard the byte and the partial word, go to BREAK.
  - BREAK: wait until the line reads 1, then go to IDLE.
- Assembler: byte k of a word goes to bits [8k+7:8k]. On the BYTES_PER_WORD-th byte, push {last, word} into the FIFO the next cycle.
  - last=1 when the frame word counter equals FRAME_WORDS-1. The counter then wraps to 0.
  - A frame error does not advance the word counter.
- FIFO full at push: the word is dropped and overflow is set. The word counter still advances, so frame alignment is preserved.
- Simultaneous pop and push while full: the pop frees a slot and the push is accepted (no overflow).
- Output: first-word-fall-through. tvalid rises exactly 1 cycle after a push into an empty FIFO.
- A beat transfers when tvalid && tready. tdata and tlast are held stable while tvalid && !tready.
- clear_err clears both sticky flags. If a new error occurs in the same cycle, set wins.
- Latency: mid-stop sample of the last byte of a word → push +1 cycle → tvalid +1 cycle.

Optional Feature:
- Macro: UART_RX_TIMESTAMP_EN.
- Defined: adds output port ts_pin_n (1 bit, reset value 1). It pulses low for exactly 64 sys_clock cycles, starting the cycle after a tlast beat transfers. It serves as the energy-measurement timestamp on the PMOD pin. A new trigger during a pulse restarts the 64-cycle count.
- Undefined: the port and its counter are absent. The rest of the behaviour is unchanged.

Decomposition:
- Package uart_rx_pkg holds:
  - RX FSM state enum (IDLE, START, DATA, STOP, BREAK)
  - CLKS_PER_BIT function
  - TS_PULSE_CYCLES=64
- One sub-module, sync_fifo_fwft (parameters WIDTH, DEPTH), with full/empty flags and registered output. The top contains the synchroniser, the FSM and the assembler.

Test Plan:
- Frame: CLKS_PER_BIT=868, send 32 bytes 0x00..0x1F with tready=1.
  - 16 beats result: tdata=0x0100, 0x0302 … 0x1F1E.
  - tlast only on beat 16.
  - No flags set.
- Backpressure: tready=0 while 10 words arrive with FIFO_DEPTH=8.
  - overflow=1.
  - Beats 9 and 10 are dropped.
  - With tready=1, exactly 8 beats drain in order with data held stable.
  - tlast falls on received word 16 regardless of the drops.
- Framing error: drive the stop bit of byte 3 as 0.
  - frame_err=1.
  - The partial word is discarded and the next valid byte pair forms the next word.
  - clear_err gives frame_err=0.
- Glitch: a 200-cycle low pulse on idle uart_rxd → no byte, no flags, FSM back to IDLE.
- Reset: assert reset during bit 4 of byte 2, release, send 2 bytes 0xAA,0x55.
  - A single beat 0x55AA results, with frame counter 0 at reset.
  - tvalid=0 while in reset.
- UART_RX_TIMESTAMP_EN: after a tlast handshake, ts_pin_n is low for 64 cycles, then high.
